// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared widths, FSM state codes and set command encodings for cache_ctrl
package cache_pkg;
    localparam int TAG_W  = 5;
    localparam int DATA_W = 16;
    localparam int WORD_W = 2;

    localparam logic [2:0] ST_INIT     = 3'd0;
    localparam logic [2:0] ST_IDLE     = 3'd1;
    localparam logic [2:0] ST_COMP     = 3'd2;
    localparam logic [2:0] ST_WB_RD    = 3'd3;
    localparam logic [2:0] ST_WB_MEM   = 3'd4;
    localparam logic [2:0] ST_FILL_MEM = 3'd5;
    localparam logic [2:0] ST_FILL_WR  = 3'd6;
    localparam logic [2:0] ST_DONE     = 3'd7;

    // Set commands packed as {comp, write}
    localparam logic [1:0] CMD_ACC_RD = 2'b00;
    localparam logic [1:0] CMD_ACC_WR = 2'b01;
    localparam logic [1:0] CMD_CMP_RD = 2'b10;
    localparam logic [1:0] CMD_CMP_WR = 2'b11;

    function automatic logic [1:0] cmp_cmd(input logic wr);
        return wr ? CMD_CMP_WR : CMD_CMP_RD;
    endfunction
endpackage

// File: rtl/cache_ctrl_if.sv
// rtl/cache_ctrl_if.sv - CPU, set-array and main-memory signal bundle for cache_ctrl
interface cache_ctrl_if #(
    parameter int INDEX_W = 3
);
    import cache_pkg::*;
    localparam int ADDR_W = TAG_W + INDEX_W + WORD_W;

    logic                cpu_req;
    logic                cpu_wr;
    logic [ADDR_W-1:0]   cpu_addr;
    logic [DATA_W-1:0]   cpu_wdata;
    logic [DATA_W-1:0]   cpu_rdata;
    logic                cpu_done;
    logic                cpu_busy;

    logic                set_en;
    logic [INDEX_W-1:0]  set_index;
    logic [WORD_W-1:0]   set_word;
    logic                set_comp;
    logic                set_write;
    logic [TAG_W-1:0]    set_tag;
    logic [DATA_W-1:0]   set_data;
    logic                set_valid;
    logic                set_hit;
    logic                set_dirty;
    logic                set_vld;
    logic [TAG_W-1:0]    set_tag_out;
    logic [DATA_W-1:0]   set_rdata;
    logic                set_ack;

    logic                mem_req;
    logic                mem_wr;
    logic [ADDR_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic [DATA_W-1:0]   mem_rdata;
    logic                mem_ack;

    modport master (
        input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_done, cpu_busy,
        output set_en, set_index, set_word, set_comp, set_write, set_tag, set_data, set_valid,
        input  set_hit, set_dirty, set_vld, set_tag_out, set_rdata, set_ack,
        output mem_req, mem_wr, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_done, cpu_busy,
        input  set_en, set_index, set_word, set_comp, set_write, set_tag, set_data, set_valid,
        output set_hit, set_dirty, set_vld, set_tag_out, set_rdata, set_ack,
        input  mem_req, mem_wr, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/set_cmd_if.sv
// rtl/set_cmd_if.sv - set-array enable/ack handshake; drops enable for a cycle after ack and pulses cmd_done
module set_cmd_if (
    input  logic clk,
    input  logic rst,
    input  logic cmd_req,
    input  logic set_ack,
    output logic set_en,
    output logic cmd_done
);
    localparam logic [1:0] PH_IDLE = 2'd0;
    localparam logic [1:0] PH_BUSY = 2'd1;
    localparam logic [1:0] PH_GAP  = 2'd2;

    logic [1:0] phase_q, phase_d;

    always_comb begin
        phase_d = phase_q;
        case (phase_q)
            PH_IDLE: if (cmd_req) phase_d = PH_BUSY;
            PH_BUSY: if (set_ack) phase_d = PH_GAP;
            default: phase_d = PH_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) phase_q <= PH_IDLE;
        else     phase_q <= phase_d;
    end

    // The gap cycle doubles as the done pulse, so a new command can never overlap the old enable
    assign set_en   = (phase_q == PH_BUSY);
    assign cmd_done = (phase_q == PH_GAP);
endmodule

// File: rtl/cache_ctrl.sv
// rtl/cache_ctrl.sv - direct-mapped write-back cache sequencer; CACHE_CTRL_STATS_EN adds hit/miss counters
module cache_ctrl
    import cache_pkg::*;
#(
    parameter int INDEX_W     = 3,
    parameter int WORDS       = 4,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    cache_ctrl_if.master  bus,
    output logic          err
`ifdef CACHE_CTRL_STATS_EN
    ,
    output logic [15:0]   hit_cnt,
    output logic [15:0]   miss_cnt
`endif
);
    localparam int ADDR_W = TAG_W + INDEX_W + WORD_W;
    localparam int TMO_W  = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TMO_W-1:0]  TMO_MAX  = TMO_W'(MEM_TIMEOUT);
    localparam logic [WORD_W-1:0] LAST_K   = WORD_W'(WORDS - 1);

    logic [2:0]          state_q, state_d;
    logic [WORD_W-1:0]   k_q, k_d;
    logic [INDEX_W-1:0]  init_idx_q, init_idx_d;
    logic [ADDR_W-1:0]   rq_addr_q, rq_addr_d;
    logic                rq_wr_q, rq_wr_d;
    logic [DATA_W-1:0]   rq_wdata_q, rq_wdata_d;
    logic                replay_q, replay_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [DATA_W-1:0]   buf_q, buf_d;
    logic                resp_hit_q, resp_dirty_q, resp_vld_q;
    logic [TAG_W-1:0]    resp_tag_q;
    logic [DATA_W-1:0]   resp_rdata_q;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                err_q, err_d;

    logic                cmd_req, cmd_done, set_en_w, resp_cap, is_hit;
    logic                mem_req_w, mem_ack_v;
    logic [1:0]          cmd;
    logic [INDEX_W-1:0]  f_index;
    logic [WORD_W-1:0]   f_word;
    logic [TAG_W-1:0]    f_tag;
    logic [DATA_W-1:0]   f_data;
    logic                f_valid;

    wire [TAG_W-1:0]   rq_tag  = rq_addr_q[ADDR_W-1 -: TAG_W];
    wire [INDEX_W-1:0] rq_idx  = rq_addr_q[WORD_W +: INDEX_W];
    wire [WORD_W-1:0]  rq_word = rq_addr_q[WORD_W-1:0];

    assign cmd_req = (state_q == ST_INIT) || (state_q == ST_COMP) ||
                     (state_q == ST_WB_RD) || (state_q == ST_FILL_WR);

    set_cmd_if u_set_cmd (
        .clk      (clk),
        .rst      (rst),
        .cmd_req  (cmd_req),
        .set_ack  (bus.set_ack),
        .set_en   (set_en_w),
        .cmd_done (cmd_done)
    );

    assign resp_cap  = set_en_w && bus.set_ack;
    assign is_hit    = resp_hit_q && resp_vld_q;
    assign mem_req_w = (state_q == ST_WB_MEM) || (state_q == ST_FILL_MEM);
    assign mem_ack_v = mem_req_w && bus.mem_ack;

    always_comb begin
        cmd     = CMD_ACC_RD;
        f_index = rq_idx;
        f_word  = k_q;
        f_tag   = rq_tag;
        f_data  = buf_q;
        f_valid = 1'b1;
        case (state_q)
            ST_INIT: begin
                cmd     = CMD_ACC_WR;
                f_index = init_idx_q;
                f_word  = '0;
                f_tag   = '0;
                f_data  = '0;
                f_valid = 1'b0;
            end
            ST_COMP: begin
                cmd    = cmp_cmd(rq_wr_q);
                f_word = rq_word;
                f_data = rq_wdata_q;
            end
            ST_FILL_WR: cmd = CMD_ACC_WR;
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        init_idx_d = init_idx_q;
        rq_addr_d  = rq_addr_q;
        rq_wr_d    = rq_wr_q;
        rq_wdata_d = rq_wdata_q;
        replay_d   = replay_q;
        rdata_d    = rdata_q;
        buf_d      = buf_q;
        case (state_q)
            ST_INIT: if (cmd_done) begin
                init_idx_d = init_idx_q + 1'b1;
                if (init_idx_q == '1) state_d = ST_IDLE;
            end
            ST_IDLE: if (bus.cpu_req) begin
                rq_addr_d  = bus.cpu_addr;
                rq_wr_d    = bus.cpu_wr;
                rq_wdata_d = bus.cpu_wdata;
                replay_d   = 1'b0;
                state_d    = ST_COMP;
            end
            ST_COMP: if (cmd_done) begin
                k_d = '0;
                if (is_hit) begin
                    state_d = ST_DONE;
                    if (!rq_wr_q) rdata_d = resp_rdata_q;
                end else if (resp_dirty_q) begin
                    state_d = ST_WB_RD;
                end else begin
                    state_d = ST_FILL_MEM;
                end
            end
            ST_WB_RD: if (cmd_done) state_d = ST_WB_MEM;
            // Write-back data and victim tag stay in the response registers until the next set command
            ST_WB_MEM: if (mem_ack_v) begin
                if (k_q == LAST_K) begin
                    k_d     = '0;
                    state_d = ST_FILL_MEM;
                end else begin
                    k_d     = k_q + 1'b1;
                    state_d = ST_WB_RD;
                end
            end
            ST_FILL_MEM: if (mem_ack_v) begin
                buf_d   = bus.mem_rdata;
                state_d = ST_FILL_WR;
            end
            ST_FILL_WR: if (cmd_done) begin
                if (k_q == LAST_K) begin
                    replay_d = 1'b1;
                    state_d  = ST_COMP;
                end else begin
                    k_d     = k_q + 1'b1;
                    state_d = ST_FILL_MEM;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_INIT;
        endcase
    end

    // Counter restarts on every new memory transaction, including back-to-back ones
    always_comb begin
        tmo_d = tmo_q;
        if (!mem_req_w || mem_ack_v) tmo_d = '0;
        else if (tmo_q != TMO_MAX)   tmo_d = tmo_q + 1'b1;
        err_d = err_q || (mem_req_w && !mem_ack_v && (tmo_q == TMO_MAX));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_INIT;
            k_q          <= '0;
            init_idx_q   <= '0;
            rq_addr_q    <= '0;
            rq_wr_q      <= 1'b0;
            rq_wdata_q   <= '0;
            replay_q     <= 1'b0;
            rdata_q      <= '0;
            buf_q        <= '0;
            resp_hit_q   <= 1'b0;
            resp_dirty_q <= 1'b0;
            resp_vld_q   <= 1'b0;
            resp_tag_q   <= '0;
            resp_rdata_q <= '0;
            tmo_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            init_idx_q <= init_idx_d;
            rq_addr_q  <= rq_addr_d;
            rq_wr_q    <= rq_wr_d;
            rq_wdata_q <= rq_wdata_d;
            replay_q   <= replay_d;
            rdata_q    <= rdata_d;
            buf_q      <= buf_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
            if (resp_cap) begin
                resp_hit_q   <= bus.set_hit;
                resp_dirty_q <= bus.set_dirty;
                resp_vld_q   <= bus.set_vld;
                resp_tag_q   <= bus.set_tag_out;
                resp_rdata_q <= bus.set_rdata;
            end
        end
    end

    assign bus.cpu_rdata = rdata_q;
    assign bus.cpu_done  = (state_q == ST_DONE);
    assign bus.cpu_busy  = !rst && (state_q != ST_IDLE);

    assign bus.set_en    = set_en_w;
    assign bus.set_index = set_en_w ? f_index : '0;
    assign bus.set_word  = set_en_w ? f_word  : '0;
    assign bus.set_comp  = set_en_w && cmd[1];
    assign bus.set_write = set_en_w && cmd[0];
    assign bus.set_tag   = set_en_w ? f_tag   : '0;
    assign bus.set_data  = set_en_w ? f_data  : '0;
    assign bus.set_valid = set_en_w && f_valid;

    assign bus.mem_req   = mem_req_w;
    assign bus.mem_wr    = (state_q == ST_WB_MEM);
    assign bus.mem_addr  = !mem_req_w ? '0 :
                           {((state_q == ST_WB_MEM) ? resp_tag_q : rq_tag), rq_idx, k_q};
    assign bus.mem_wdata = (state_q == ST_WB_MEM) ? resp_rdata_q : '0;
    assign err           = err_q;

`ifdef CACHE_CTRL_STATS_EN
    logic [15:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (state_q == ST_COMP && cmd_done) begin
            if (is_hit) begin
                if (!replay_q && hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 16'd1;
            end else if (miss_cnt_q != '1) begin
                miss_cnt_d = miss_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`endif
endmodule

// File: tb/tb_cache_ctrl.sv
// tb/tb_cache_ctrl.sv - directed bench for cache_ctrl with behavioural set array and main memory
module tb_cache_ctrl;
    localparam int INDEX_W     = 3;
    localparam int MEM_TIMEOUT = 255;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic err;
    always #5 clk = ~clk;

    cache_ctrl_if #(.INDEX_W(INDEX_W)) bus ();
`ifdef CACHE_CTRL_STATS_EN
    logic [15:0] hit_cnt, miss_cnt;
`endif

    cache_ctrl #(.INDEX_W(INDEX_W), .WORDS(4), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .err (err)
`ifdef CACHE_CTRL_STATS_EN
        ,
        .hit_cnt  (hit_cnt),
        .miss_cnt (miss_cnt)
`endif
    );

    // Set-array model: acks one cycle after it sees enable, outputs held until the next command
    logic [4:0]  m_tag   [8];
    logic        m_vld   [8];
    logic        m_dirty [8];
    logic [15:0] m_data  [8][4];
    int          inv_q [$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.set_ack <= 1'b0;
        end else if (bus.set_ack) begin
            bus.set_ack <= 1'b0;
        end else if (bus.set_en) begin : set_op
            int   i;
            int   w;
            logic h;
            i = int'(bus.set_index);
            w = int'(bus.set_word);
            h = m_vld[i] && (m_tag[i] == bus.set_tag);
            bus.set_ack     <= 1'b1;
            bus.set_hit     <= bus.set_comp && h;
            bus.set_dirty   <= m_dirty[i];
            bus.set_vld     <= m_vld[i];
            bus.set_tag_out <= m_tag[i];
            bus.set_rdata   <= m_data[i][w];
            if (bus.set_write && !bus.set_comp) begin
                m_data[i][w] <= bus.set_data;
                m_tag[i]     <= bus.set_tag;
                m_vld[i]     <= bus.set_valid;
                m_dirty[i]   <= 1'b0;
                if (!bus.set_valid) inv_q.push_back(i);
            end else if (bus.set_write && h) begin
                m_data[i][w] <= bus.set_data;
                m_dirty[i]   <= 1'b1;
            end
        end
    end

    // Memory model: read data is {6'h04, addr}; ack after two cycles of request
    logic        mem_stall;
    int          mem_wait;
    logic [9:0]  wr_addr_q [$];
    logic [15:0] wr_data_q [$];
    logic [9:0]  rd_addr_q [$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.mem_ack <= 1'b0;
            mem_wait = 0;
        end else begin
            bus.mem_ack <= 1'b0;
            if (bus.mem_req && !bus.mem_ack && !mem_stall) begin
                if (mem_wait == 1) begin
                    mem_wait = 0;
                    bus.mem_ack <= 1'b1;
                    if (bus.mem_wr) begin
                        wr_addr_q.push_back(bus.mem_addr);
                        wr_data_q.push_back(bus.mem_wdata);
                    end else begin
                        bus.mem_rdata <= {6'h04, bus.mem_addr};
                        rd_addr_q.push_back(bus.mem_addr);
                    end
                end else begin
                    mem_wait = mem_wait + 1;
                end
            end else begin
                mem_wait = 0;
            end
        end
    end

    int          cyc = 0;
    int          done_cnt = 0;
    int          ack_cyc = 0;
    int          done_cyc = 0;
    logic [15:0] done_rdata;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (bus.set_ack) ack_cyc = cyc;
        if (bus.cpu_done) begin
            done_cnt   = done_cnt + 1;
            done_cyc   = cyc;
            done_rdata = bus.cpu_rdata;
        end
    end

    int passed = 0;
    int failed = 0;
    int total  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run(input logic wr, input logic [9:0] addr, input logic [15:0] wd,
                       input bit poke, output int nd);
        int d0;
        d0 = done_cnt;
        @(negedge clk);
        bus.cpu_req   = 1'b1;
        bus.cpu_wr    = wr;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wd;
        @(negedge clk);
        bus.cpu_req = 1'b0;
        if (poke) begin
            repeat (6) @(negedge clk);
            bus.cpu_req   = 1'b1;
            bus.cpu_wr    = 1'b1;
            bus.cpu_addr  = 10'h3FF;
            bus.cpu_wdata = 16'hDEAD;
            repeat (3) @(negedge clk);
            bus.cpu_req = 1'b0;
        end
        for (int n = 0; n < 3000 && done_cnt == d0; n++) @(negedge clk);
        repeat (4) @(negedge clk);
        nd = done_cnt - d0;
    endtask

    task automatic wait_init(input int b_inv);
        logic [7:0] mask;
        for (int n = 0; n < 300 && bus.cpu_busy; n++) @(negedge clk);
        check("init_inv_count", inv_q.size() - b_inv, 8);
        mask = '0;
        for (int j = b_inv; j < inv_q.size() && j < b_inv + 8; j++) mask[inv_q[j][2:0]] = 1'b1;
        check("init_inv_mask", mask, 8'hFF);
    endtask

    initial begin
        int nd;
        int b_rd;
        int b_wr;
        int b_inv;
        int n;
        bus.cpu_req   = 1'b0;
        bus.cpu_wr    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        mem_stall     = 1'b0;

        #1;
        check("rst_cpu_done", bus.cpu_done, 0);
        check("rst_set_en",   bus.set_en,   0);
        check("rst_mem_req",  bus.mem_req,  0);
        check("rst_err",      err,          0);
        check("rst_cpu_busy", bus.cpu_busy, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("init_busy", bus.cpu_busy, 1);
        wait_init(0);

        // Cold read miss: tag=3 idx=2 word=1
        b_rd = rd_addr_q.size(); b_wr = wr_addr_q.size();
        run(1'b0, 10'h069, 16'h0, 1'b0, nd);
        check("rd1_done",      nd, 1);
        check("rd1_rdata",     done_rdata, 16'h1069);
        check("rd1_mem_rd",    rd_addr_q.size() - b_rd, 4);
        check("rd1_mem_wr",    wr_addr_q.size() - b_wr, 0);
        check("rd1_fill0",     rd_addr_q[b_rd], 10'h068);
        check("rd1_fill3",     rd_addr_q[b_rd + 3], 10'h06B);

        // Same read hits
        b_rd = rd_addr_q.size();
        run(1'b0, 10'h069, 16'h0, 1'b0, nd);
        check("rd2_done",      nd, 1);
        check("rd2_rdata",     done_rdata, 16'h1069);
        check("rd2_mem_rd",    rd_addr_q.size() - b_rd, 0);
        check("rd2_latency",   done_cyc - ack_cyc, 2);

        // Write hit then read back
        b_rd = rd_addr_q.size(); b_wr = wr_addr_q.size();
        run(1'b1, 10'h068, 16'hBEEF, 1'b0, nd);
        check("wr_done",       nd, 1);
        check("wr_mem_traffic", (rd_addr_q.size() - b_rd) + (wr_addr_q.size() - b_wr), 0);
        check("wr_dirty",      m_dirty[2], 1);
        run(1'b0, 10'h068, 16'h0, 1'b0, nd);
        check("rdb_done",      nd, 1);
        check("rdb_rdata",     done_rdata, 16'hBEEF);

        // Conflict miss on dirty set: tag=7 idx=2 word=2, with ignored requests while busy
        b_rd = rd_addr_q.size(); b_wr = wr_addr_q.size();
        run(1'b0, 10'h0EA, 16'h0, 1'b1, nd);
        check("wb_done",       nd, 1);
        check("wb_count",      wr_addr_q.size() - b_wr, 4);
        check("wb_addr0",      wr_addr_q[b_wr], 10'h068);
        check("wb_data0",      wr_data_q[b_wr], 16'hBEEF);
        check("wb_data1",      wr_data_q[b_wr + 1], 16'h1069);
        check("wb_addr3",      wr_addr_q[b_wr + 3], 10'h06B);
        check("fill_count",    rd_addr_q.size() - b_rd, 4);
        check("fill_addr0",    rd_addr_q[b_rd], 10'h0E8);
        check("fill_addr3",    rd_addr_q[b_rd + 3], 10'h0EB);
        check("wb_rdata",      done_rdata, 16'h10EA);
        check("poke_idle",     bus.cpu_busy, 0);
        check("done_vs_accepted", done_cnt, 5);
`ifdef CACHE_CTRL_STATS_EN
        check("stat_hit",      hit_cnt, 3);
        check("stat_miss",     miss_cnt, 2);
`endif

        // Memory timeout on a fill of tag=9 idx=5
        mem_stall = 1'b1;
        @(negedge clk);
        bus.cpu_req  = 1'b1;
        bus.cpu_wr   = 1'b0;
        bus.cpu_addr = 10'h134;
        @(negedge clk);
        bus.cpu_req = 1'b0;
        for (n = 0; n < 100 && !bus.mem_req; n++) @(negedge clk);
        check("tmo_mem_req_rise", bus.mem_req, 1);
        for (n = 0; n < 400 && !err; n++) @(negedge clk);
        check("tmo_err",       err, 1);
        check("tmo_delay_ok",  (n >= MEM_TIMEOUT) && (n <= MEM_TIMEOUT + 2), 1);
        repeat (5) @(negedge clk);
        check("tmo_req_held",  bus.mem_req, 1);
        check("tmo_addr_held", bus.mem_addr, 10'h134);
`ifdef CACHE_CTRL_STATS_EN
        check("stat_miss_tmo", miss_cnt, 3);
`endif

        // Reset mid-fill
        b_inv = inv_q.size();
        rst = 1'b1;
        mem_stall = 1'b0;
        #1;
        check("rst2_err",      err, 0);
        check("rst2_done",     bus.cpu_done, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst2_init",     bus.cpu_busy, 1);
        wait_init(b_inv);
        check("rst2_no_done",  done_cnt, 5);
`ifdef CACHE_CTRL_STATS_EN
        check("rst2_stat_hit", hit_cnt, 0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/cache_ctrl.md
Name: cache_ctrl

Overview:
- Sequencing FSM for a direct-mapped, write-back, write-allocate cache built from an array of 4-word sets (5-bit tag, 16-bit words).
- Sits between the CPU port and the set array, and drives the set command interface (enable/comp/write/rst).
- On a miss it runs dirty write-back and line fill against main memory, then replays the original access.

Parameters:
- INDEX_W, 3, set-index width; number of sets = 2**INDEX_W.
- WORDS, 4, words per set; word field is 2 bits.
- MEM_TIMEOUT, 255, cycles without mem_ack before the error flag sets.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_req  in  1  access request; sampled only in IDLE.
- cpu_wr  in  1  1 = write, 0 = read.
- cpu_addr  in  7+INDEX_W  address; bit 0 is MSB: tag [0:4], index [5:4+INDEX_W], word last 2 bits.
- cpu_wdata  in  16  write data.
- cpu_rdata  out  16  read data, valid when cpu_done=1.
- cpu_done  out  1  one-cycle completion pulse.
- cpu_busy  out  1  high in every state except IDLE.
- set_en  out  1  set-array enable.
- set_index  out  INDEX_W  selected set.
- set_word  out  2  word select.
- set_comp  out  1  compare mode.
- set_write  out  1  write mode.
- set_tag  out  5  tag to the set.
- set_data  out  16  data to the set.
- set_valid  out  1  valid to the set.
- set_hit  in  1  hit from the set.
- set_dirty  in  1  dirty from the set.
- set_vld  in  1  valid from the set.
- set_tag_out  in  5  stored tag.
- set_rdata  in  16  word read data.
- set_ack  in  1  set command done.
- mem_req  out  1  memory request, level.
- mem_wr  out  1  memory write.
- mem_addr  out  7+INDEX_W  word address.
- mem_wdata  out  16  memory write data.
- mem_rdata  in  16  memory read data.
- mem_ack  in  1  memory done, one cycle.
- err  out  1  sticky memory-timeout flag.

Behaviour:
- Reset (async): state INIT. All outputs 0.
  - INIT issues set_en with set_write=1, comp=0, valid=0 (invalidate) to each index 0..2**INDEX_W-1, then goes to IDLE.
  - Reset mid-operation aborts the access; no cpu_done is issued.
- Set handshake:
  - Drive the command fields, raise set_en, hold all fields stable until set_ack=1.
  - The cycle after ack, set_en=0 for at least one cycle (the set responds to enable edges).
  - Each set command therefore costs at least 2 cycles.
- IDLE: when cpu_req=1, latch addr, wr and wdata into an internal request register, then go to COMP. cpu_req in any other state is ignored.
- COMP: compare read or compare write at the latched word.
  - Hit (set_hit and set_vld) -> DONE; on a read, cpu_rdata = set_rdata.
  - Miss and set_dirty=1 -> WB_RD, word counter k = 0.
  - Miss and not dirty -> FILL_MEM, k = 0.
- WB_RD: access read of word k; capture set_tag_out and set_rdata -> WB_MEM.
- WB_MEM: mem_req=1, mem_wr=1, mem_addr = {stored tag, index, k}, hold until mem_ack.
  - k == WORDS-1 -> FILL_MEM with k = 0; otherwise k+1 -> WB_RD.
- FILL_MEM: mem_req=1, mem_wr=0, mem_addr = {latched tag, index, k}; capture mem_rdata on mem_ack -> FILL_WR.
- FILL_WR: access write of word k with set_tag = latched tag, set_valid=1 (clears dirty).
  - k == WORDS-1 -> COMP (replay, which now hits); otherwise k+1 -> FILL_MEM.
- DONE: cpu_done=1 for exactly one cycle -> IDLE. A write hit marks the set dirty inside the set.
- Timeout: a counter clears on each mem_req rise. Reaching MEM_TIMEOUT sets err, keeps mem_req asserted and does not leave the state. err clears only on reset.
- k is 2 bits and wraps; the terminal test is on WORDS-1, not on overflow.
- mem_ack while mem_req=0 is ignored.

Optional Feature:
- Macro: CACHE_CTRL_STATS_EN.
- Defined: two 16-bit saturating counters, hit_cnt and miss_cnt, exposed as outputs.
  - hit_cnt increments on a COMP hit that is not a replay.
  - miss_cnt increments on each COMP miss.
  - Both reset to 0.
- Undefined: the counter ports and logic are absent.

Decomposition:
- Package cache_pkg:
  - TAG_W=5, DATA_W=16, WORD_W=2.
  - State enum: INIT, IDLE, COMP, WB_RD, WB_MEM, FILL_MEM, FILL_WR, DONE.
  - Set command encoding constants (comp/write pairs).
- Sub-module set_cmd_if: wraps the enable/ack/drop-enable handshake and returns a one-cycle cmd_done.

Test Plan:
- Reset, then read addr tag=3 idx=2 word=1 -> INIT invalidates all 8 sets; miss; no write-back; 4 mem reads at words 0..3; replay hit; cpu_rdata = memory word; cpu_done pulses once.
- Repeat the same read -> hit, cpu_done 2 cycles after the COMP set_ack, no mem_req.
- Write 0xBEEF to tag=3 idx=2 word=0, then read it -> hit both times; read returns 0xBEEF.
- Read tag=7 idx=2 after that write -> 4 mem writes at tag=3 idx=2 words 0..3, the first carrying 0xBEEF; then 4 fills from tag=7; replay hit.
- Hold mem_ack=0 for MEM_TIMEOUT cycles -> err=1, mem_req stays high; assert rst -> err=0, state INIT, no cpu_done.
- Assert cpu_req while busy -> ignored; completion count equals accepted-request count.
